fp_div_seq: RTL
===============

# fp_div_seq

Iterative IEEE-754 floating-point divider; the divide counterpart to the team's gated floating-point multiplier, with the same operand format, rounding-mode encoding and 8-bit status byte. Computes z = a / b by restoring radix-2 mantissa division, one quotient bit per clock, under a start/done handshake. Sits beside the multiplier in the arithmetic datapath, where area matters more than throughput. Subnormal inputs flush to zero and subnormal results flush to zero.

## Interface
- sig_width, 23, fraction bits
- exp_width, 8, exponent bits; bias = 2^(exp_width-1)-1
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when busy=0
- a  input  sig_width+exp_width+1  dividend, captured on accept
- b  input  sig_width+exp_width+1  divisor, captured on accept
- rnd  input  3  rounding mode, captured on accept
- DG_ctrl  input  1  datapath gating; present only with FP_DIV_DG_EN
- busy  output  1  high from the cycle after accept through the done cycle
- done  output  1  one-cycle pulse; z/status valid that cycle and held until next done
- z  output  sig_width+exp_width+1  quotient
- status  output  8  bit0 zero, bit1 infinity, bit2 invalid, bit3 tiny, bit4 huge, bit5 inexact, bit6 0, bit7 divide-by-zero

## Operation
- FSM states: IDLE, CHECK, DIVIDE, ROUND, DONE.
- IDLE: start=1 captures a, b, rnd → CHECK.
- CHECK: classify operands. Exponent 0 counts as zero, regardless of fraction.
  - NaN operand, 0/0, or inf/inf → z = canonical qNaN (exp all ones, fraction MSB set, sign 0), status 0x04.
  - Finite nonzero / 0 → signed inf, 0x82.
  - inf / finite → signed inf, 0x02.
  - 0 / nonzero, or finite / inf → signed zero, 0x01.
  - Any special case → DONE.
  - Otherwise: sign = sa^sb; e = ea-eb+bias; ma = 1.fa, mb = 1.fb. If ma<mb, shift ma left 1 and decrement e. → DIVIDE.
- DIVIDE: sig_width+2 iterations. Each: if rem≥mb, rem -= mb and q bit = 1. Then rem <<= 1. The quotient is 1 integer bit, sig_width fraction bits and a guard bit; sticky = (rem≠0).
- ROUND: apply rnd.
  - 0 nearest-even, 1 toward zero, 2 toward +inf, 3 toward -inf, 4 nearest-up, 5 away from zero; 6/7 treated as 0.
  - Mantissa carry-out renormalizes and increments e.
  - inexact = guard|sticky.
  - Overflow (e ≥ 2^exp_width-1): inf if the mode rounds away in the sign direction (0, 4, 5, or 2 with +, or 3 with -); otherwise max finite. Set huge and inexact; set infinity when the result is inf.
  - Underflow (e ≤ 0): signed zero, status zero|tiny|inexact.
  - → DONE.
- DONE: drive done=1, register z/status → IDLE.
- Arithmetic widths: e carried in exp_width+2 signed bits. Remainder is sig_width+2 bits. Iteration counter is clog2(sig_width+3) bits.

## Timing
- Reset (async assert, sync release): state IDLE, busy=0, done=0, z=0, status=0, internal registers 0.
- Accept at edge T (start=1, busy=0).
- Normal operands: done high in cycle T+sig_width+5 (28 for single precision).
- Special operands: done high in cycle T+2.
- start while busy=1 is ignored; no queueing.
- start may be asserted in the done cycle; busy=1 there, so it is ignored. Back-to-back minimum issue interval is latency+1.
- Reset mid-operation aborts immediately with no done pulse; outputs go to reset values.
- z and status change only in the done cycle.

## Configuration
- FP_DIV_DG_EN defined:
  - DG_ctrl port exists.
  - DG_ctrl=0 in IDLE blocks accept and holds the operand registers.
  - DG_ctrl=0 during an operation freezes the FSM, counter and datapath. Completion is delayed by exactly the number of gated cycles.
  - z and status hold throughout.
- FP_DIV_DG_EN undefined: no DG_ctrl port; behaviour as if DG_ctrl=1.

## Structure
- Shared package fp_div_pkg holds:
  - FSM state enum.
  - Status bit index constants.
  - Rounding mode constants.
  - Canonical NaN/inf builder functions.
- One sub-module, fp_div_round: combinational rounding and exception packing. Inputs: sign, e, quotient, guard, sticky, rnd. Outputs: z, status.

## Test plan
- 0x40C00000 / 0x40000000, rnd 0 → done at T+28, z 0x40400000, status 0x00, busy low the next cycle.
- 0x3F800000 / 0x40400000: rnd 0 → 0x3EAAAAAB, 0x20; rnd 1 → 0x3EAAAAAA, 0x20; rnd 3 with sign bit of a set → 0xBEAAAAAB.
- Specials, all with done at T+2:
  - 0x3F800000 / 0x00000000 → 0x7F800000, 0x82.
  - 0/0 → 0x7FC00000, 0x04.
  - 0x3F800000 / 0x7F800000 → 0x00000000, 0x01.
- Overflow 0x7F000000 / 0x00800000:
  - rnd 0 → 0x7F800000, 0x32.
  - rnd 1 → 0x7F7FFFFF, 0x30.
- Underflow 0x00800000 / 0x40000000 → 0x00000000, status 0x29.
- Control:
  - Second start at T+5 is ignored and the first result is unchanged.
  - rst_n low at T+10: no done, and z/status read 0.
  - With FP_DIV_DG_EN, DG_ctrl low for 4 cycles mid-divide → done at T+32 with the correct result.

Source files
------------

// File: rtl/fp_div_pkg.sv
// Shared types and helpers for the sequential floating-point divider:
// FSM states, status bit positions, rounding modes and special-value builders.
package fp_div_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DIVIDE,
    S_ROUND,
    S_DONE
  } state_t;

  localparam int ST_ZERO    = 0;
  localparam int ST_INF     = 1;
  localparam int ST_INVALID = 2;
  localparam int ST_TINY    = 3;
  localparam int ST_HUGE    = 4;
  localparam int ST_INEXACT = 5;
  localparam int ST_DIVZ    = 7;

  localparam logic [2:0] RND_NE = 3'd0;
  localparam logic [2:0] RND_TZ = 3'd1;
  localparam logic [2:0] RND_UP = 3'd2;
  localparam logic [2:0] RND_DN = 3'd3;
  localparam logic [2:0] RND_NU = 3'd4;
  localparam logic [2:0] RND_AW = 3'd5;

  // Builders return a 64-bit word; callers cast down to their operand width.
  function automatic logic [63:0] inf_word(input int sw, input int ew, input logic s);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < ew; i++) w = w | (64'd1 << (sw + i));
    w = w | (64'(s) << (sw + ew));
    return w;
  endfunction

  function automatic logic [63:0] qnan_word(input int sw, input int ew);
    return inf_word(sw, ew, 1'b0) | (64'd1 << (sw - 1));
  endfunction

  function automatic logic [63:0] max_word(input int sw, input int ew, input logic s);
    logic [63:0] w;
    w = inf_word(sw, ew, s) & ~(64'd1 << sw);
    for (int i = 0; i < sw; i++) w = w | (64'd1 << i);
    return w;
  endfunction

endpackage

// File: rtl/fp_div_round.sv
// Combinational rounding and exception packing for the divider quotient
// (hidden bit + fraction, guard, sticky) with overflow/underflow handling.
module fp_div_round
  import fp_div_pkg::*;
#(
  parameter int sig_width = 23,
  parameter int exp_width = 8
) (
  input  logic                           sign,
  input  logic signed [exp_width+1:0]    e,
  input  logic [sig_width:0]             quo,
  input  logic                           guard,
  input  logic                           sticky,
  input  logic [2:0]                     rnd,
  output logic [sig_width+exp_width:0]   z,
  output logic [7:0]                     status
);

  localparam int W   = sig_width + exp_width + 1;
  localparam int EW2 = exp_width + 2;
  localparam int MW  = sig_width + 1;
  localparam logic signed [EW2-1:0] E_TOP  = EW2'((2 ** exp_width) - 1);
  localparam logic signed [EW2-1:0] E_ZERO = '0;

  logic [2:0]            mode;
  logic                  inc, away, gs;
  logic [MW:0]           sum;
  logic [MW-1:0]         mant;
  logic signed [EW2-1:0] e_adj;
  logic [W-1:0]          inf_z, max_z;

  assign inf_z = W'(inf_word(sig_width, exp_width, sign));
  assign max_z = W'(max_word(sig_width, exp_width, sign));

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    mode   = (rnd > RND_AW) ? RND_NE : rnd;
    gs     = guard | sticky;
    inc    = 1'b0;
    away   = 1'b1;
    case (mode)
      RND_NE:  inc = guard & (sticky | quo[0]);
      RND_TZ:  away = 1'b0;
      RND_UP:  begin inc = ~sign & gs; away = ~sign; end
      RND_DN:  begin inc = sign & gs;  away = sign;  end
      RND_NU:  inc = guard;
      default: inc = gs;
    endcase

    sum = {1'b0, quo} + {{MW{1'b0}}, inc};
    if (sum[MW]) begin
      mant  = sum[MW:1];
      e_adj = e + EW2'(1);
    end else begin
      mant  = sum[MW-1:0];
      e_adj = e;
    end

    z                  = {sign, e_adj[exp_width-1:0], mant[sig_width-1:0]};
    status             = '0;
    status[ST_INEXACT] = gs;
    if (e_adj >= E_TOP) begin
      status[ST_HUGE]    = 1'b1;
      status[ST_INEXACT] = 1'b1;
      status[ST_INF]     = away;
      z                  = away ? inf_z : max_z;
    end else if (e_adj <= E_ZERO) begin
      z                  = {sign, {(W-1){1'b0}}};
      status[ST_ZERO]    = 1'b1;
      status[ST_TINY]    = 1'b1;
      status[ST_INEXACT] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Iterative IEEE-754 divider, one restoring quotient bit per clock, start/done
// handshake. Optional datapath gating via DG_ctrl when FP_DIV_DG_EN is defined.
module fp_div_seq
  import fp_div_pkg::*;
#(
  parameter int sig_width = 23,
  parameter int exp_width = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [sig_width+exp_width:0]   a,
  input  logic [sig_width+exp_width:0]   b,
  input  logic [2:0]                     rnd,
`ifdef FP_DIV_DG_EN
  input  logic                           DG_ctrl,
`endif
  output logic                           busy,
  output logic                           done,
  output logic [sig_width+exp_width:0]   z,
  output logic [7:0]                     status
);

  localparam int W    = sig_width + exp_width + 1;
  localparam int EW2  = exp_width + 2;
  localparam int MW   = sig_width + 1;
  localparam int RW   = sig_width + 2;
  localparam int CW   = $clog2(sig_width + 3);
  localparam int BIAS = (2 ** (exp_width - 1)) - 1;

  state_t                state;
  logic [W-1:0]          a_r, b_r, res_z, spec_z, rnd_z;
  logic [2:0]            rnd_r;
  logic                  sign_r;
  logic signed [EW2-1:0] e_r, e_init;
  logic [MW-1:0]         mb_r, ma, mb;
  logic [RW-1:0]         rem_r, q_r, rem_sub;
  logic [CW-1:0]         cnt_r;
  logic [7:0]            res_st, spec_st, rnd_st;
  logic                  en, spec_hit, sign_q, rem_ge;

`ifdef FP_DIV_DG_EN
  assign en = DG_ctrl;
`else
  assign en = 1'b1;
`endif

  logic [exp_width-1:0] ea, eb;
  logic [sig_width-1:0] fa, fb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign ea     = a_r[W-2:sig_width];
  assign eb     = b_r[W-2:sig_width];
  assign fa     = a_r[sig_width-1:0];
  assign fb     = b_r[sig_width-1:0];
  // Exponent zero is treated as zero whatever the fraction: subnormals flush.
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) & ~(|fa);
  assign b_inf  = (&eb) & ~(|fb);
  assign a_nan  = (&ea) & (|fa);
  assign b_nan  = (&eb) & (|fb);
  assign sign_q = a_r[W-1] ^ b_r[W-1];
  assign ma     = {1'b1, fa};
  assign mb     = {1'b1, fb};
  assign e_init = $signed({2'b00, ea}) - $signed({2'b00, eb}) + EW2'(BIAS);

  always_comb begin
    spec_hit = 1'b1;
    spec_z   = {sign_q, {(W-1){1'b0}}};
    spec_st  = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_z              = W'(qnan_word(sig_width, exp_width));
      spec_st[ST_INVALID] = 1'b1;
    end else if (b_zero && !a_inf) begin
      spec_z           = W'(inf_word(sig_width, exp_width, sign_q));
      spec_st[ST_INF]  = 1'b1;
      spec_st[ST_DIVZ] = 1'b1;
    end else if (a_inf) begin
      spec_z          = W'(inf_word(sig_width, exp_width, sign_q));
      spec_st[ST_INF] = 1'b1;
    end else if (a_zero || b_inf) begin
      spec_st[ST_ZERO] = 1'b1;
    end else begin
      spec_hit = 1'b0;
    end
  end

  assign rem_ge  = (rem_r >= {1'b0, mb_r});
  assign rem_sub = rem_ge ? (rem_r - {1'b0, mb_r}) : rem_r;

  fp_div_round #(.sig_width(sig_width), .exp_width(exp_width)) u_round (
    .sign   (sign_r),
    .e      (e_r),
    .quo    (q_r[RW-1:1]),
    .guard  (q_r[0]),
    .sticky (|rem_r),
    .rnd    (rnd_r),
    .z      (rnd_z),
    .status (rnd_st)
  );

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      z      <= '0;
      status <= '0;
      a_r    <= '0;
      b_r    <= '0;
      rnd_r  <= '0;
      sign_r <= 1'b0;
      e_r    <= '0;
      mb_r   <= '0;
      rem_r  <= '0;
      q_r    <= '0;
      cnt_r  <= '0;
      res_z  <= '0;
      res_st <= '0;
    end else begin
      if (done) begin
        done <= 1'b0;
        busy <= 1'b0;
      end
      if (en) begin
        case (state)
          S_IDLE: if (start && !busy) begin
            a_r   <= a;
            b_r   <= b;
            rnd_r <= rnd;
            busy  <= 1'b1;
            state <= S_CHECK;
          end
          S_CHECK: begin
            sign_r <= sign_q;
            mb_r   <= mb;
            q_r    <= '0;
            cnt_r  <= '0;
            if (spec_hit) begin
              res_z  <= spec_z;
              res_st <= spec_st;
              state  <= S_DONE;
            end else begin
              // Pre-normalise so the first quotient bit is always the integer 1.
              if (ma < mb) begin
                rem_r <= {ma, 1'b0};
                e_r   <= e_init - EW2'(1);
              end else begin
                rem_r <= {1'b0, ma};
                e_r   <= e_init;
              end
              state <= S_DIVIDE;
            end
          end
          S_DIVIDE: begin
            rem_r <= {rem_sub[RW-2:0], 1'b0};
            q_r   <= {q_r[RW-2:0], rem_ge};
            cnt_r <= cnt_r + CW'(1);
            if (cnt_r == CW'(RW - 1)) state <= S_ROUND;
          end
          S_ROUND: begin
            res_z  <= rnd_z;
            res_st <= rnd_st;
            state  <= S_DONE;
          end
          S_DONE: begin
            z      <= res_z;
            status <= res_st;
            done   <= 1'b1;
            state  <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
